// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter for the unified-memory pd5 pipeline.
// The load/store requester (D) normally has priority over instruction fetch
// (I). A starvation guard forces an I grant after STARVE_LIMIT consecutive
// D grants that were made while I was waiting. Each access runs for
// MEM_LATENCY cycles against a fixed-latency memory, then one response cycle
// returns the captured data to whichever requester owned the access.

module mem_port_arbiter #(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_i,
  input  logic [AWIDTH-1:0] i_addr_i,
  output logic              i_gnt_o,
  output logic              i_rvalid_o,
  output logic [DWIDTH-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  input  logic [2:0]        d_size_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic [2:0]        mem_size_o,
  output logic              mem_ren_o,
  output logic              mem_wen_o,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic              busy_o
);

  // Fetches are always full-word reads.
  localparam logic [2:0] MEM_WORD = 3'b010;

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [LAT_W-1:0]  lat_cnt;
  logic [STV_W-1:0]  starve_cnt;
  logic              owner_d_q;
  logic              we_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [2:0]        size_q;
  logic [DWIDTH-1:0] i_rdata_q;
  logic [DWIDTH-1:0] d_rdata_q;

  logic grant;
  logic last_access;

  assign grant       = i_gnt_o | d_gnt_o;
  assign last_access = (state == ACCESS) && (lat_cnt == LAT_LAST);

  assign busy_o     = (state != IDLE);
  assign i_rvalid_o = (state == RESP) && !owner_d_q;
  assign d_rvalid_o = (state == RESP) &&  owner_d_q;
  assign i_rdata_o  = i_rdata_q;
  assign d_rdata_o  = d_rdata_q;

  // Next-state, grant selection and memory-port decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_nxt   = state;
    i_gnt_o     = 1'b0;
    d_gnt_o     = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_size_o  = 3'b000;
    mem_ren_o   = 1'b0;
    mem_wen_o   = 1'b0;
    case (state)
      IDLE: begin
        // Grants are masked while reset is held so every output reads 0.
        if (rst) begin
          if (d_req_i && (!i_req_i || starve_cnt != STV_MAX)) begin
            d_gnt_o = 1'b1;
          end else if (i_req_i) begin
            i_gnt_o = 1'b1;
          end
        end
        if (grant) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_size_o  = size_q;
        mem_ren_o   = !we_q;
        // A store writes only in its first access cycle.
        mem_wen_o   = we_q && (lat_cnt == '0);
        if (lat_cnt == LAT_LAST) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same point in time.
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the winning request and track consecutive D grants over a waiting I.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the latched request and data registers are reset as well, because
    // every output must read 0 while reset is asserted.
    if (!rst) begin
      owner_d_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= 3'b000;
      starve_cnt <= '0;
    end else if (grant) begin
      owner_d_q <= d_gnt_o;
      we_q      <= d_gnt_o & d_we_i;
      addr_q    <= d_gnt_o ? d_addr_i  : i_addr_i;
      wdata_q   <= d_gnt_o ? d_wdata_i : '0;
      size_q    <= d_gnt_o ? d_size_i  : MEM_WORD;
      if (d_gnt_o && i_req_i) begin
        if (starve_cnt != STV_MAX) begin
          starve_cnt <= starve_cnt + STV_W'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  // Access-cycle counter; sits at 0 outside ACCESS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt <= '0;
    end else if (state == ACCESS) begin
      lat_cnt <= lat_cnt + LAT_W'(1);
    end else begin
      lat_cnt <= '0;
    end
  end

  // Capture read data on the last access cycle; stores return 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (last_access) begin
      if (owner_d_q) begin
        d_rdata_q <= we_q ? '0 : mem_rdata_i;
      end else begin
        i_rdata_q <= mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus random traffic.
// A reference model predicts grants, port activity and responses from the
// arbitration rules; responses are queued at grant time and popped by the
// monitor whenever the DUT raises rvalid.

module tb_mem_port_arbiter;

  localparam int ML  = 2;
  localparam int SL  = 4;
  localparam int ML1 = 1;
  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] INIT_MEM [16] = '{
    32'h0050_0093, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
    32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777,
    32'h8888_8888, 32'h9999_9999, 32'hAAAA_AAAA, 32'hBBBB_BBBB,
    32'hCCCC_CCCC, 32'hDDDD_DDDD, 32'hEEEE_EEEE, 32'hFFFF_0000
  };

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        i_req, i_gnt_o, i_rvalid_o;
  logic [31:0] i_addr, i_rdata_o;
  logic        d_req, d_we, d_gnt_o, d_rvalid_o;
  logic [31:0] d_addr, d_wdata, d_rdata_o;
  logic [2:0]  d_size;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [2:0]  mem_size_o;
  logic        mem_ren_o, mem_wen_o, busy_o;

  // Second instance for the MEM_LATENCY = 1 timing check.
  logic        i_req1, i_gnt1, i_rvalid1;
  logic [31:0] i_addr1, i_rdata1;
  logic        d_gnt1, d_rvalid1;
  logic [31:0] d_rdata1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;
  logic [2:0]  mem_size1;
  logic        mem_ren1, mem_wen1, busy1;
  bit          dut1_done = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wen_cnt = 0;
  int d_rv_cnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LATENCY(ML), .STARVE_LIMIT(SL)) u_dut (
    .clk(clk), .rst(rst),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_size_i(d_size), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
    .mem_ren_o(mem_ren_o), .mem_wen_o(mem_wen_o), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LATENCY(ML1), .STARVE_LIMIT(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req_i(i_req1), .i_addr_i(i_addr1), .i_gnt_o(i_gnt1),
    .i_rvalid_o(i_rvalid1), .i_rdata_o(i_rdata1),
    .d_req_i(1'b0), .d_we_i(1'b0), .d_addr_i(32'h0), .d_wdata_i(32'h0),
    .d_size_i(3'b000), .d_gnt_o(d_gnt1), .d_rvalid_o(d_rvalid1), .d_rdata_o(d_rdata1),
    .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1), .mem_size_o(mem_size1),
    .mem_ren_o(mem_ren1), .mem_wen_o(mem_wen1), .mem_rdata_i(mem_rdata1),
    .busy_o(busy1)
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory behind the main DUT: read data is only valid on the last access cycle.
  logic [31:0] phys_mem [16] = INIT_MEM;
  int acc_cyc = 0;

  always @(posedge clk) begin
    if (mem_wen_o) phys_mem[mem_addr_o[5:2]] <= mem_wdata_o;
    if (mem_ren_o) acc_cyc <= acc_cyc + 1;
    else           acc_cyc <= 0;
    if (mem_wen_o)  wen_cnt  <= wen_cnt + 1;
    if (d_rvalid_o) d_rv_cnt <= d_rv_cnt + 1;
  end

  always_comb begin
    mem_rdata_i = 32'hBAD0_0BAD;
    if (mem_ren_o && acc_cyc == ML - 1) mem_rdata_i = phys_mem[mem_addr_o[5:2]];
  end

  assign mem_rdata1 = mem_ren1 ? (mem_addr1 ^ 32'h1234_5678) : 32'h0;

  // Reference model and scoreboard.
  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
  } txn_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        i_q[$];
  exp_t        d_q[$];
  logic [31:0] ref_mem [16] = INIT_MEM;
  txn_t        cur;
  bit          have_txn = 1'b0;
  int          g_cyc = 0;
  int          starve_m = 0;

  always @(negedge clk) begin : monitor
    exp_t        e;
    bit          in_flight, acc, exp_i, exp_d;
    int          k;
    logic [31:0] wmask;
    if (!rst) begin
      check("reset_outputs", 160'({i_gnt_o, i_rvalid_o, i_rdata_o, d_gnt_o, d_rvalid_o,
            d_rdata_o, mem_addr_o, mem_wdata_o, mem_size_o, mem_ren_o, mem_wen_o, busy_o}), 160'(0));
      have_txn = 1'b0;
      starve_m = 0;
      i_q.delete();
      d_q.delete();
    end else begin
      k         = cyc - g_cyc;
      in_flight = have_txn && (k <= ML + 1);
      acc       = in_flight && (k <= ML);
      wmask     = (acc && !cur.we) ? 32'h0 : 32'hFFFF_FFFF;
      check("mem_port",
            160'({busy_o, mem_ren_o, mem_wen_o, mem_addr_o, mem_size_o, mem_wdata_o & wmask}),
            160'({in_flight, acc && !cur.we, acc && cur.we && k == 1,
                  acc ? cur.addr : 32'h0, acc ? cur.size : 3'b000,
                  (acc && cur.we) ? cur.wdata : 32'h0}));

      if (i_rvalid_o) begin
        if (i_q.size() == 0) check("i_rvalid_unexpected", 160'(1), 160'(0));
        else begin
          e = i_q.pop_front();
          check("i_rdata", 160'(i_rdata_o), 160'(e.data));
          check("i_rvalid_cycle", 160'(cyc), 160'(e.due));
        end
      end
      if (i_q.size() > 0 && i_q[0].due < cyc) begin
        check("i_rvalid_missing", 160'(0), 160'(1));
        i_q.delete(0);
      end
      if (d_rvalid_o) begin
        if (d_q.size() == 0) check("d_rvalid_unexpected", 160'(1), 160'(0));
        else begin
          e = d_q.pop_front();
          check("d_rdata", 160'(d_rdata_o), 160'(e.data));
          check("d_rvalid_cycle", 160'(cyc), 160'(e.due));
        end
      end
      if (d_q.size() > 0 && d_q[0].due < cyc) begin
        check("d_rvalid_missing", 160'(0), 160'(1));
        d_q.delete(0);
      end

      exp_i = 1'b0;
      exp_d = 1'b0;
      if (!in_flight) begin
        if (d_req && (!i_req || starve_m != SL)) exp_d = 1'b1;
        else if (i_req)                          exp_i = 1'b1;
      end
      check("grant", 160'({i_gnt_o, d_gnt_o}), 160'({exp_i, exp_d}));

      if (exp_i || exp_d) begin
        cur.is_d  = exp_d;
        cur.we    = exp_d && d_we;
        cur.addr  = exp_d ? d_addr : i_addr;
        cur.wdata = d_wdata;
        cur.size  = exp_d ? d_size : 3'b010;
        g_cyc     = cyc;
        have_txn  = 1'b1;
        if (exp_i)      starve_m = 0;
        else if (i_req) starve_m = (starve_m < SL) ? starve_m + 1 : SL;
        else            starve_m = 0;
        e.due = cyc + ML + 1;
        if (cur.we) begin
          ref_mem[cur.addr[5:2]] = cur.wdata;
          e.data = 32'h0;
        end else begin
          e.data = ref_mem[cur.addr[5:2]];
        end
        if (exp_i) i_q.push_back(e);
        else       d_q.push_back(e);
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    return BASE | (32'($urandom_range(0, 15)) << 2);
  endfunction

  task automatic wait_gnt(input bit is_d, output int gcyc);
    gcyc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (is_d ? d_gnt_o : i_gnt_o) begin
        gcyc = cyc;
        break;
      end
    end
    if (gcyc < 0) check(is_d ? "d_gnt_timeout" : "i_gnt_timeout", 160'(0), 160'(1));
  endtask

  task automatic wait_rvalid(input bit is_d, output int rcyc, output logic [31:0] data);
    rcyc = -1;
    data = 32'h0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (is_d ? d_rvalid_o : i_rvalid_o) begin
        rcyc = cyc;
        data = is_d ? d_rdata_o : i_rdata_o;
        break;
      end
    end
    if (rcyc < 0) check(is_d ? "d_rvalid_timeout" : "i_rvalid_timeout", 160'(0), 160'(1));
  endtask

  // MEM_LATENCY = 1: fetch responds at grant+2, next grant at grant+3.
  initial begin
    int g, g2, r;
    logic [31:0] rd;
    i_req1  = 1'b0;
    i_addr1 = BASE + 32'h8;
    g = -1; g2 = -1; r = -1; rd = 32'h0;
    for (int n = 0; n < 50 && !rst; n++) @(posedge clk);
    @(posedge clk);
    #1 i_req1 = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (i_gnt1 && g < 0)       g = cyc;
      else if (i_gnt1 && g2 < 0) g2 = cyc;
      if (i_rvalid1 && r < 0) begin
        r  = cyc;
        rd = i_rdata1;
      end
      if (g2 >= 0) break;
    end
    #1 i_req1 = 1'b0;
    check("lat1_gnt_seen", 160'(g >= 0), 160'(1));
    check("lat1_rvalid_cycle", 160'(r), 160'(g + 2));
    check("lat1_rdata", 160'(rd), 160'((BASE + 32'h8) ^ 32'h1234_5678));
    check("lat1_next_gnt", 160'(g2), 160'(g + 3));
    dut1_done = 1'b1;
  end

  // Main stimulus.
  initial begin
    int c0, c1, g, g2, r, w0, rv0;
    logic [31:0] data;
    logic [9:0]  pattern;
    bit ig, dg;

    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_size = 3'b000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Single fetch.
    @(posedge clk); #1;
    c0 = cyc; i_addr = BASE; i_req = 1'b1;
    wait_gnt(1'b0, g);
    check("fetch_gnt_cycle", 160'(g), 160'(c0));
    @(posedge clk); #1 i_req = 1'b0;
    wait_rvalid(1'b0, r, data);
    check("fetch_rvalid_cycle", 160'(r), 160'(c0 + 3));
    check("fetch_data", 160'(data), 160'(32'h0050_0093));

    // Store then load to the same word.
    @(posedge clk); #1;
    w0 = wen_cnt;
    d_req = 1'b1; d_we = 1'b1; d_addr = BASE + 32'h10; d_wdata = 32'hDEAD_BEEF; d_size = 3'b010;
    wait_gnt(1'b1, g);
    @(posedge clk); #1 d_req = 1'b0;
    wait_rvalid(1'b1, r, data);
    check("store_rdata", 160'(data), 160'(0));
    check("store_wen_count", 160'(wen_cnt - w0), 160'(1));
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_wdata = 32'h0;
    wait_gnt(1'b1, g);
    @(posedge clk); #1 d_req = 1'b0;
    wait_rvalid(1'b1, r, data);
    check("load_after_store", 160'(data), 160'(32'hDEAD_BEEF));

    // Simultaneous requests: D first, I once D is done.
    @(posedge clk); #1;
    c0 = cyc;
    i_req = 1'b1; i_addr = BASE + 32'h4;
    d_req = 1'b1; d_we = 1'b0; d_addr = BASE + 32'h8;
    wait_gnt(1'b1, g);
    check("simul_d_gnt", 160'(g), 160'(c0));
    @(posedge clk); #1 d_req = 1'b0;
    wait_gnt(1'b0, g2);
    check("simul_i_gnt", 160'(g2), 160'(c0 + 4));
    @(posedge clk); #1 i_req = 1'b0;
    wait_rvalid(1'b0, r, data);

    // Starvation guard: both held, the fifth grant goes to I.
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = BASE + 32'hC;
    d_req = 1'b1; d_we = 1'b0; d_addr = BASE + 32'h20;
    pattern = '0;
    for (int n = 0; n < 10; n++) begin
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
        @(negedge clk);
        if (i_gnt_o || d_gnt_o) begin
          pattern = {pattern[8:0], i_gnt_o};
          seen = 1'b1;
        end
      end
      if (!seen) check("starve_gnt_timeout", 160'(0), 160'(1));
    end
    check("starve_pattern", 160'(pattern), 160'(10'b0000100001));
    @(posedge clk); #1 i_req = 1'b0; d_req = 1'b0;
    repeat (ML + 3) @(posedge clk);

    // Reset during the second access cycle of a store.
    #1;
    w0 = wen_cnt; rv0 = d_rv_cnt;
    d_req = 1'b1; d_we = 1'b1; d_addr = BASE + 32'h14; d_wdata = 32'hCAFE_F00D; d_size = 3'b010;
    wait_gnt(1'b1, g);
    @(posedge clk); #1 d_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 160'({busy_o, mem_wen_o, d_rvalid_o}), 160'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    c1 = cyc;
    d_req = 1'b1; d_we = 1'b0; d_wdata = 32'h0;
    wait_gnt(1'b1, g2);
    check("post_reset_gnt", 160'(g2), 160'(c1));
    @(posedge clk); #1 d_req = 1'b0;
    wait_rvalid(1'b1, r, data);
    check("aborted_store_data", 160'(data), 160'(32'hCAFE_F00D));
    @(posedge clk); #1;
    check("aborted_store_wen", 160'(wen_cnt - w0), 160'(1));
    check("aborted_store_rvalids", 160'(d_rv_cnt - rv0), 160'(1));

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      ig = i_gnt_o;
      dg = d_gnt_o;
      @(posedge clk); #1;
      if ((i_req && ig) || !i_req) begin
        i_req  = ($urandom_range(0, 2) == 0);
        i_addr = rand_addr();
      end else if ($urandom_range(0, 15) == 0) begin
        i_req = 1'b0;
      end
      if ((d_req && dg) || !d_req) begin
        d_req   = ($urandom_range(0, 1) == 1);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = rand_addr();
        d_wdata = $urandom;
        d_size  = 3'($urandom_range(0, 7));
      end else if ($urandom_range(0, 15) == 0) begin
        d_req = 1'b0;
      end
    end
    @(posedge clk); #1 i_req = 1'b0; d_req = 1'b0;
    repeat (ML + 4) @(posedge clk);
    #1;
    check("i_queue_drained", 160'(i_q.size()), 160'(0));
    check("d_queue_drained", 160'(d_q.size()), 160'(0));

    for (int n = 0; n < 100 && !dut1_done; n++) @(posedge clk);
    if (!dut1_done) check("lat1_timeout", 160'(0), 160'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single shared memory port between the instruction-fetch requester (I) and the memory-stage load/store requester (D) for the unified-memory variant of the pd5 pipeline. It sequences each access through a fixed-latency memory and returns read data to the owning requester. Requesters stall while they wait for grant or response. Priority is fixed, D over I, with a starvation guard that protects fetch.

## Interface
- AWIDTH, 32, address width
- DWIDTH, 32, data width
- MEM_LATENCY, 2, cycles from access start to valid mem_rdata_i; legal range ≥1
- STARVE_LIMIT, 4, consecutive D grants with I pending before I is forced; legal range ≥1
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- i_req_i  in  1  fetch request; held until i_gnt_o
- i_addr_i  in  AWIDTH  fetch address (always word read)
- i_gnt_o  out  1  fetch request accepted (comb, IDLE only)
- i_rvalid_o  out  1  one-cycle pulse, i_rdata_o valid
- i_rdata_o  out  DWIDTH  fetched instruction
- d_req_i  in  1  load/store request; held until d_gnt_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  AWIDTH  data address
- d_wdata_i  in  DWIDTH  store data
- d_size_i  in  3  funct3 size encoding, passed to memory
- d_gnt_o  out  1  data request accepted (comb, IDLE only)
- d_rvalid_o  out  1  one-cycle pulse; load data valid or store complete
- d_rdata_o  out  DWIDTH  load data (0 for stores)
- mem_addr_o  out  AWIDTH  memory address
- mem_wdata_o  out  DWIDTH  memory write data
- mem_size_o  out  3  memory size encoding (MEM_WORD for I)
- mem_ren_o  out  1  memory read enable
- mem_wen_o  out  1  memory write enable
- mem_rdata_i  in  DWIDTH  memory read data
- busy_o  out  1  state ≠ IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE, selection (comb):
  - only one req high: that requester wins.
  - both high: D wins, unless starve_cnt == STARVE_LIMIT, in which case I wins.
- Grant: the winner's gnt_o is high this cycle. Its addr/wdata/size/we and owner are latched at the edge. Next state ACCESS, lat_cnt = 0. Requester must drop or replace req after the gnt edge.
- ACCESS:
  - mem_addr_o, mem_wdata_o, mem_size_o driven from latched regs.
  - mem_ren_o = 1 every ACCESS cycle for loads and fetches.
  - mem_wen_o = 1 only in the first ACCESS cycle (lat_cnt == 0) for stores, giving exactly one write per store.
  - lat_cnt increments each cycle. At lat_cnt == MEM_LATENCY-1: mem_rdata_i is captured (reads only; stores capture 0), then next state RESP.
- RESP: owner's rvalid_o = 1 with captured data; the other rvalid_o = 0; next state IDLE.
- No grant is issued in ACCESS or RESP, and requests arriving then wait. A req dropped before its grant has no effect.
- starve_cnt, updated only on grant edges:
  - D granted while i_req_i high: increment, saturating at STARVE_LIMIT.
  - I granted: clear to 0.
  - D granted with i_req_i low: clear to 0.
- Outside ACCESS all mem_* outputs are 0. rdata outputs hold their last captured value; only rvalid qualifies them.

## Timing
- Grant-to-response latency: grant in cycle t, ACCESS in t+1..t+MEM_LATENCY, rvalid in t+MEM_LATENCY+1, earliest next grant in t+MEM_LATENCY+2.
- Peak throughput is one access per MEM_LATENCY+2 cycles. For MEM_LATENCY = 2 that is one access per 4 cycles.
- gnt_o is combinational from req in IDLE. rvalid_o, rdata_o and mem_* are registered/state-decoded, with no combinational path from req.
- Reset asserted (rst = 0), at any time and immediately, asynchronously:
  - state IDLE; lat_cnt, starve_cnt, latched regs and rdata regs cleared.
  - all outputs 0.
  - an in-flight access is abandoned with no rvalid.
  - a store aborted after its first ACCESS cycle is not repeated.
- Reset release: the first grant is possible in the first cycle with rst = 1.

## Test plan
- Single fetch, MEM_LATENCY = 2, memory returns 0x00500093 for addr 0x01000000: i_req at cycle 0 -> i_gnt cycle 0, mem_ren cycles 1–2, i_rvalid cycle 3 with 0x00500093, busy_o cycles 1–3.
- Store then load to 0x01000010: store wdata 0xDEADBEEF, size 3'b010 -> mem_wen high exactly one cycle, d_rvalid with d_rdata 0. Following load -> d_rdata 0xDEADBEEF.
- Simultaneous req, starve_cnt 0: i_req and d_req both high at cycle 0 -> d_gnt cycle 0. i_gnt cycle 4 after D completes, since d_req has dropped.
- Starvation, STARVE_LIMIT = 4: i_req and d_req held high continuously -> four D grants, then the 5th grant goes to I. starve_cnt returns to 0, then D wins again.
- Reset mid-access: store granted, rst driven low in the second ACCESS cycle -> all outputs 0 that cycle, no d_rvalid, one mem_wen total. After release, a new d_req is granted in the first cycle.
- MEM_LATENCY = 1 parameter sweep: fetch -> rvalid at grant+2, next grant at grant+3.
